global_mem_responder: RTL



---
 rtl/global_mem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/global_mem_responder.sv
// Responder end of the GPU global-memory request interface: an on-chip array of
// 128-bit lines answering one request at a time after a fixed latency plus optional LFSR jitter.
module global_mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 4,
    parameter int          JITTER_EN  = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         globalEnable,
    input  logic         globalWriteEnable,
    input  logic [25:0]  globalMemAddr,
    input  logic [127:0] globalMemDataWrite,
    input  logic [7:0]   writeBytes,
    output logic [127:0] globalMemReadData,
    output logic         globalMemFinishedAction,
    output logic         busy,
    output logic [15:0]  completedCount,
    output logic [1:0]   debugState
);

    // Handshake: a request is taken at any edge where globalEnable=1 in IDLE; all
    // request fields are latched there. globalMemFinishedAction pulses for one cycle
    // when it is done, and the initiator must drop globalEnable on that pulse.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } stateT;

    localparam int CNT_W = $clog2(LATENCY + 3) + 1;

    stateT                  state;
    stateT                  nextState;
    logic [CNT_W-1:0]       cnt;
    logic [15:0]            lfsr;
    logic                   lfsrFb;
    logic [1:0]             jitter;
    logic [DEPTH_LOG2-1:0]  addrQ;
    logic [127:0]           wdataQ;
    logic [7:0]             wbQ;
    logic                   writeQ;

    logic [127:0] mem [0:(2**DEPTH_LOG2)-1];

    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign jitter = (JITTER_EN != 0) ? lfsr[1:0] : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            lfsr              <= LFSR_SEED;
            cnt               <= '0;
            addrQ             <= '0;
            wdataQ            <= '0;
            wbQ               <= '0;
            writeQ            <= 1'b0;
            globalMemReadData <= '0;
            completedCount    <= '0;
        end else begin
            state <= nextState;
            lfsr  <= {lfsr[14:0], lfsrFb};
            case (state)
                S_IDLE: begin
                    if (globalEnable) begin
                        addrQ  <= globalMemAddr[DEPTH_LOG2-1:0];
                        wdataQ <= globalMemDataWrite;
                        wbQ    <= writeBytes;
                        writeQ <= globalWriteEnable;
                        cnt    <= CNT_W'(LATENCY - 1) + CNT_W'(jitter);
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                S_ACCESS: begin
                    if (!writeQ) globalMemReadData <= mem[addrQ];
                end
                S_DONE: begin
                    // Counted on leaving DONE so a reset during DONE suppresses it.
                    completedCount <= completedCount + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; writes are masked per halfword.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS && writeQ) begin
            for (int i = 0; i < 8; i++) begin
                if (wbQ[i]) mem[addrQ][16*i +: 16] <= wdataQ[16*i +: 16];
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (globalEnable) nextState = S_WAIT;
            S_WAIT:   if (cnt == '0) nextState = S_ACCESS;
            S_ACCESS: nextState = S_DONE;
            S_DONE:   nextState = S_IDLE;
            default:  nextState = S_IDLE;
        endcase
    end

    assign globalMemFinishedAction = (state == S_DONE);
    assign busy                    = (state != S_IDLE);
    assign debugState              = state;

endmodule
